// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the memory port arbiter.
//   arbState_e      : arbiter FSM states (ARB, BURST)
//   WIDTH_DEFAULT   : default address/data width of the shared memory port
//   STARVE_DEFAULT  : default number of consecutive losses an IO request may
//                     take before it is forced to win
//   cntBits()       : width of a counter that must hold 0..maxVal
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arbState_e;

    localparam int WIDTH_DEFAULT  = 36;
    localparam int STARVE_DEFAULT = 4;

    // $clog2(maxVal+1), floored at one bit so STARVE=0 still yields a legal vector.
    function automatic int cntBits(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the pipeline data port (CPU) and an
// IO loader. CPU normally wins; an IO request that has lost STARVE consecutive
// cycles is forced through. The IO loader may hold the port for a burst with
// io_lock. Grants are combinational; read data returns one cycle after grant.
//
// Ports
//   clock                 in   single clock, rising edge
//   reset                 in   asynchronous, active-low
//   cpu_req, cpu_we       in   CPU request / write strobe
//   cpu_addr, cpu_wdata   in   CPU address / store data      [WIDTH]
//   io_req, io_we         in   IO request / write strobe
//   io_lock               in   IO burst hold
//   io_addr, io_wdata     in   IO address / data             [WIDTH]
//   cpu_gnt, io_gnt       out  access accepted this cycle
//   cpu_rvalid, io_rvalid out  read data valid for that requester
//   rdata                 out  shared read data              [WIDTH]
//   stall                 out  cpu_req & !cpu_gnt
//   mem_we                out  memory write enable
//   mem_addr, mem_wdata   out  memory address / write data   [WIDTH]
//   mem_rdata             in   memory read data, one cycle after address
//
// State | meaning
// ------+---------------------------------------------------------------
// ARB   | normal arbitration: CPU priority with IO starvation override
// BURST | IO holds the port; io_gnt follows io_req, CPU is blocked
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int STARVE = STARVE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,

    input  logic             io_req,
    input  logic             io_we,
    input  logic             io_lock,
    input  logic [WIDTH-1:0] io_addr,
    input  logic [WIDTH-1:0] io_wdata,

    output logic             cpu_gnt,
    output logic             io_gnt,
    output logic             cpu_rvalid,
    output logic             io_rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,

    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int               CNT_W      = cntBits(STARVE);
    localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE);

    arbState_e        state;
    arbState_e        stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             starved;
    logic             cpuWin;
    logic             ioWin;

    assign starved = io_req && (waitCnt == STARVE_CNT);

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        cpuWin      = 1'b0;
        ioWin       = 1'b0;

        case (state)
            ARB: begin
                if (cpu_req && !starved) begin
                    cpuWin = 1'b1;
                end else if (io_req) begin
                    ioWin = 1'b1;
                end

                if (ioWin && io_lock) begin
                    stateNext = BURST;
                end

                // Count consecutive IO losses; saturate so the override stays armed.
                if (io_req && !ioWin) begin
                    if (waitCnt != STARVE_CNT) begin
                        waitCntNext = waitCnt + CNT_W'(1);
                    end
                end else begin
                    waitCntNext = '0;
                end
            end

            BURST: begin
                ioWin       = io_req;
                waitCntNext = '0;
                // The cycle that drops lock or req is still served as part of the burst.
                if (!io_lock || !io_req) begin
                    stateNext = ARB;
                end
            end

            default: begin
                stateNext   = ARB;
                waitCntNext = '0;
            end
        endcase
    end

    // No access may reach the memory while reset is held, even though the
    // grant path is otherwise purely combinational.
    assign cpu_gnt = cpuWin & reset;
    assign io_gnt  = ioWin & reset;
    assign stall   = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (io_gnt) begin
            mem_we    = io_we;
            mem_addr  = io_addr;
            mem_wdata = io_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ARB;
            waitCnt    <= '0;
            cpu_rvalid <= 1'b0;
            io_rvalid  <= 1'b0;
        end else begin
            state      <= stateNext;
            waitCnt    <= waitCntNext;
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            io_rvalid  <= io_gnt & ~io_we;
        end
    end

    assign rdata = (cpu_rvalid || io_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int W = 36;

    logic         clock;
    logic         reset;
    logic         cpu_req, cpu_we;
    logic [W-1:0] cpu_addr, cpu_wdata;
    logic         io_req, io_we, io_lock;
    logic [W-1:0] io_addr, io_wdata;
    logic         cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, stall;
    logic [W-1:0] rdata;
    logic         mem_we;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.WIDTH(W), .STARVE(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .io_req(io_req), .io_we(io_we), .io_lock(io_lock), .io_addr(io_addr), .io_wdata(io_wdata),
        .cpu_gnt(cpu_gnt), .io_gnt(io_gnt), .cpu_rvalid(cpu_rvalid), .io_rvalid(io_rvalid),
        .rdata(rdata), .stall(stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: read data is a fixed function of the address, one cycle later.
    function automatic logic [W-1:0] memFn(input logic [W-1:0] a);
        return (a == 36'h10) ? 36'hABC : ((a ^ 36'hF0F0F0F0F) + 36'd3);
    endfunction

    always @(posedge clock) mem_rdata <= memFn(mem_addr);

    typedef struct {
        logic         cReq, cWe;
        logic [W-1:0] cAddr, cData;
        logic         iReq, iWe, iLock;
        logic [W-1:0] iAddr, iData;
        logic         eCpu, eIo, eStall;
    } vec_t;

    typedef struct {
        int           due;
        logic         isCpu;
        logic [W-1:0] data;
    } rd_t;

    vec_t vecs[$];
    rd_t  sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    task automatic add(input logic cReq, input logic cWe, input logic [W-1:0] cAddr,
                       input logic [W-1:0] cData, input logic iReq, input logic iWe,
                       input logic iLock, input logic [W-1:0] iAddr, input logic [W-1:0] iData,
                       input logic eCpu, input logic eIo, input logic eStall);
        vec_t v;
        v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cData = cData;
        v.iReq = iReq; v.iWe = iWe; v.iLock = iLock; v.iAddr = iAddr; v.iData = iData;
        v.eCpu = eCpu; v.eIo = eIo; v.eStall = eStall;
        vecs.push_back(v);
    endtask

    task automatic idle();
        add(0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic drive(input vec_t v);
        cpu_req = v.cReq; cpu_we = v.cWe; cpu_addr = v.cAddr; cpu_wdata = v.cData;
        io_req = v.iReq; io_we = v.iWe; io_lock = v.iLock; io_addr = v.iAddr; io_wdata = v.iData;
    endtask

    // Called at the falling edge: compares combinational outputs against the
    // vector, registered read outputs against the scoreboard, then queues any
    // read this cycle is expected to launch.
    task automatic checkOutputs(input vec_t v, input string tag);
        logic         eWe, eCr, eIr;
        logic [W-1:0] eAddr, eData, eRd;
        eWe = 1'b0; eAddr = '0; eData = '0;
        if (v.eCpu) begin
            eWe = v.cWe; eAddr = v.cAddr; eData = v.cData;
        end else if (v.eIo) begin
            eWe = v.iWe; eAddr = v.iAddr; eData = v.iData;
        end
        check({tag, ".cpu_gnt"},   W'(cpu_gnt), W'(v.eCpu));
        check({tag, ".io_gnt"},    W'(io_gnt),  W'(v.eIo));
        check({tag, ".stall"},     W'(stall),   W'(v.eStall));
        check({tag, ".mem_we"},    W'(mem_we),  W'(eWe));
        check({tag, ".mem_addr"},  mem_addr,    eAddr);
        check({tag, ".mem_wdata"}, mem_wdata,   eData);

        eCr = 1'b0; eIr = 1'b0; eRd = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            rd_t r;
            r = sb.pop_front();
            eCr = r.isCpu; eIr = !r.isCpu; eRd = r.data;
        end
        check({tag, ".cpu_rvalid"}, W'(cpu_rvalid), W'(eCr));
        check({tag, ".io_rvalid"},  W'(io_rvalid),  W'(eIr));
        check({tag, ".rdata"},      rdata,          eRd);

        if (v.eCpu && !v.cWe) begin
            rd_t r;
            r.due = cyc + 1; r.isCpu = 1'b1; r.data = memFn(v.cAddr);
            sb.push_back(r);
        end
        if (v.eIo && !v.iWe) begin
            rd_t r;
            r.due = cyc + 1; r.isCpu = 1'b0; r.data = memFn(v.iAddr);
            sb.push_back(r);
        end
    endtask

    task automatic nextEdge();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic runCycle(input vec_t v, input string tag);
        drive(v);
        @(negedge clock);
        checkOutputs(v, tag);
        nextEdge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Idle port.
        idle(); idle();
        // CPU read at 0x10, then a CPU write.
        add(1, 0, 36'h10, '0, 0, 0, 0, '0, '0, 1, 0, 0);
        idle();
        add(1, 1, 36'h20, 36'h123, 0, 0, 0, '0, '0, 1, 0, 0);
        idle();
        // Contention without lock: IO forced through on the fifth cycle.
        for (int i = 0; i < 6; i++)
            add(1, 0, 36'(i + 'h30), '0, 1, 0, 0, 36'(i + 'h40), '0, i != 4, i == 4, i == 4);
        idle();
        // Contention with lock: IO starves through, then holds the port.
        for (int i = 0; i < 7; i++)
            add(1, 0, 36'(i + 'h50), '0, 1, 0, 1, 36'(i + 'h60), '0, i < 4, i >= 4, i >= 4);
        add(1, 0, 36'h57, '0, 0, 0, 0, '0, '0, 0, 0, 1);
        add(1, 0, 36'h58, '0, 0, 0, 0, '0, '0, 1, 0, 0);
        idle();
        // Burst whose final cycle drops lock but still gets served.
        add(0, 0, '0, '0, 1, 0, 1, 36'h70, '0, 0, 1, 0);
        add(1, 0, 36'h71, '0, 1, 0, 0, 36'h72, '0, 0, 1, 1);
        add(1, 0, 36'h73, '0, 1, 0, 0, 36'h74, '0, 1, 0, 0);
        idle();
        // IO write burst to addresses 0..7.
        for (int i = 0; i < 8; i++)
            add(0, 0, '0, '0, 1, 1, i < 7, 36'(i), 36'(i + 'h100), 0, 1, 0);
        idle();

        // Reset with requests pending: nothing may be granted.
        cpu_req = 1; cpu_we = 0; cpu_addr = 36'h10; cpu_wdata = '0;
        io_req = 1; io_we = 0; io_lock = 1; io_addr = 36'h11; io_wdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst.cpu_gnt",    W'(cpu_gnt),    '0);
        check("rst.io_gnt",     W'(io_gnt),     '0);
        check("rst.mem_we",     W'(mem_we),     '0);
        check("rst.cpu_rvalid", W'(cpu_rvalid), '0);
        check("rst.io_rvalid",  W'(io_rvalid),  '0);
        check("rst.rdata",      rdata,          '0);
        v.cReq = 0; v.cWe = 0; v.cAddr = '0; v.cData = '0;
        v.iReq = 0; v.iWe = 0; v.iLock = 0; v.iAddr = '0; v.iData = '0;
        v.eCpu = 0; v.eIo = 0; v.eStall = 0;
        drive(v);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            runCycle(vecs[i], $sformatf("row%0d", i));

        // Reset pulsed during a burst with an IO read in flight.
        v.cReq = 0; v.cWe = 0; v.cAddr = '0; v.cData = '0;
        v.iReq = 1; v.iWe = 0; v.iLock = 1; v.iAddr = 36'h55; v.iData = '0;
        v.eCpu = 0; v.eIo = 1; v.eStall = 0;
        runCycle(v, "burst0");
        v.cReq = 1; v.cAddr = 36'h57; v.iAddr = 36'h56; v.eStall = 1;
        drive(v);
        @(negedge clock);
        checkOutputs(v, "burst1");
        #1 reset = 1'b0;
        #1;
        check("midrst.io_gnt",  W'(io_gnt),  '0);
        check("midrst.cpu_gnt", W'(cpu_gnt), '0);
        check("midrst.mem_we",  W'(mem_we),  '0);
        sb.delete();
        nextEdge();
        check("midrst.io_rvalid",  W'(io_rvalid),  '0);
        check("midrst.cpu_rvalid", W'(cpu_rvalid), '0);
        check("midrst.rdata",      rdata,          '0);
        check("midrst.io_gnt2",    W'(io_gnt),     '0);
        // Release with both requesting under lock: CPU wins only if back in ARB.
        v.cReq = 1; v.cWe = 0; v.cAddr = 36'h77;
        v.iReq = 1; v.iWe = 0; v.iLock = 1; v.iAddr = 36'h78;
        v.eCpu = 1; v.eIo = 0; v.eStall = 0;
        drive(v);
        reset = 1'b1;
        runCycle(v, "postrst");
        v.cReq = 0; v.iReq = 0; v.iLock = 0; v.cAddr = '0; v.iAddr = '0;
        v.eCpu = 0; v.eIo = 0;
        runCycle(v, "postrst_idle");
        runCycle(v, "final_idle");

        check("sb_empty", W'(sb.size()), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
